vector_mem_seq: RTL
===================

VECTOR_MEM_SEQ -- requirements
Module: vector_mem_seq

Interface
REQ-001 Parameter STRIDE, default 1: address increment between consecutive vector elements, in 16-bit words.
REQ-002 Clk1  input  1: sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1: asynchronous, active-low reset.
REQ-004 start  input  1: request a 16-element vector transfer; sampled only in IDLE.
REQ-005 is_store  input  1: 1 = VST (register to memory), 0 = VLD (memory to register); sampled with start.
REQ-006 base_addr  input  16: address of element 0; sampled with start.
REQ-007 st_data  input  256: vector to store; element i in bits [16i+15:16i]; sampled with start.
REQ-008 DataIn  input  16: memory read data, valid combinationally in any cycle with RD=1.
REQ-009 Addr  output  16: memory word address.
REQ-010 RD  output  1: memory read strobe.
REQ-011 WR  output  1: memory write strobe.
REQ-012 dataOut  output  16: memory write data, meaningful only when WR=1.
REQ-013 ld_data  output  256: assembled load vector, element i in bits [16i+15:16i].
REQ-014 busy  output  1: high while in XFER or DONE.
REQ-015 done  output  1: one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, XFER and DONE.
REQ-017 In IDLE, start=1 at a rising edge SHALL latch is_store, base_addr and st_data, clear the element counter idx to 0, and enter XFER.
REQ-018 In XFER, Addr SHALL equal (base + idx*STRIDE) mod 2^16; address wrap past 0xFFFF is silent.
REQ-019 In XFER with a load, RD SHALL be 1, WR 0, and DataIn SHALL be written into element idx of ld_data at the closing edge of the cycle.
REQ-020 In XFER with a store, WR SHALL be 1, RD 0, and dataOut SHALL equal the latched st_data element idx.
REQ-021 idx SHALL increment by 1 on every XFER cycle; the edge on which idx=15 SHALL move the FSM to DONE.
REQ-022 XFER SHALL last exactly 16 cycles, one element per cycle, with no stalls.
REQ-023 DONE SHALL last one cycle with done=1, RD=0 and WR=0, then return to IDLE.
REQ-024 Latency: with start sampled at edge E, the first memory access occurs in the cycle after E, and done is high in the 17th cycle after E.
REQ-025 start SHALL be ignored in XFER and DONE; a new transfer is never queued.
REQ-026 start asserted in the first IDLE cycle after DONE SHALL be accepted.
REQ-027 Changes to base_addr, st_data or is_store after acceptance SHALL have no effect on the current transfer.
REQ-028 ld_data SHALL hold its value in IDLE and during stores; a load overwrites all 16 elements.
REQ-029 In IDLE and DONE, Addr and dataOut SHALL be 0.
REQ-030 RD and WR SHALL never be high in the same cycle.

Reset
REQ-031 Reset low SHALL immediately force IDLE, idx=0, RD=0, WR=0, done=0, busy=0, Addr=0, dataOut=0 and ld_data=0, regardless of the clock.
REQ-032 Reset asserted mid-XFER SHALL abort the transfer with no further memory strobes; after release, the block is idle until a new start arrives.

Verification
REQ-033 Load with base=0x0100, memory[0x0100+i]=0xA000+i -> RD high for 16 cycles at Addr 0x0100..0x010F, done in cycle 17, ld_data element i = 0xA000+i.
REQ-034 Store with base=0x2000, st_data element i = 0x1111*i (mod 2^16) -> 16 WR cycles at Addr 0x2000..0x200F with the matching dataOut, RD never high.
REQ-035 Load with base=0xFFFC -> Addr sequence 0xFFFC..0xFFFF then 0x0000..0x000B.
REQ-036 start pulsed at XFER idx=5 and again during DONE -> both ignored; start in the next IDLE cycle -> new transfer begins on the following cycle.
REQ-037 Reset asserted at idx=8 of a store -> WR drops asynchronously and all outputs are 0; the next start runs a full 16-element transfer from idx 0.
REQ-038 STRIDE=4 with base=0x0010 -> Addr sequence 0x0010, 0x0014, ..., 0x004C.

Source files
------------

// File: rtl/vector_mem_seq.sv
// vector_mem_seq: sequences one 16-element vector load or store against a
// 16-bit word memory, one element per cycle with no stalls.
// Memory-side outputs and status outputs come straight from flops.
module vector_mem_seq #(
  parameter int STRIDE = 1
) (
  input  logic         Clk1,
  input  logic         Reset,
  input  logic         start,
  input  logic         is_store,
  input  logic [15:0]  base_addr,
  input  logic [255:0] st_data,
  input  logic [15:0]  DataIn,
  output logic [15:0]  Addr,
  output logic         RD,
  output logic         WR,
  output logic [15:0]  dataOut,
  output logic [255:0] ld_data,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Address increment per element, reduced to the 16-bit address space.
  localparam logic [15:0] STEP = 16'(STRIDE);

  // Element i of a packed 16 x 16-bit vector.
  function automatic logic [15:0] elem(input logic [255:0] vec, input logic [3:0] i);
    return vec[{i, 4'b0000} +: 16];
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic           store_q, store_d;
  logic [255:0]   st_q, st_d;
  logic [255:0]   ld_q, ld_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    dout_q, dout_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [3:0]     idx_nxt_s;

  assign idx_nxt_s = idx_q + 4'd1;

  // Next-state and next-output logic; every output register is computed for
  // the cycle it will be presented in, so strobes line up with the state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    store_d = store_q;
    st_d    = st_q;
    ld_d    = ld_q;
    addr_d  = 16'h0000;
    dout_d  = 16'h0000;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = XFER;
          idx_d   = 4'd0;
          store_d = is_store;
          st_d    = st_data;
          addr_d  = base_addr;
          rd_d    = ~is_store;
          wr_d    = is_store;
          dout_d  = is_store ? st_data[15:0] : 16'h0000;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        // Load data for the current element is captured at the closing edge.
        if (!store_q) begin
          ld_d[{idx_q, 4'b0000} +: 16] = DataIn;
        end else begin
          ld_d = ld_q;
        end
        busy_d = 1'b1;
        if (idx_q == 4'd15) begin
          state_d = DONE;
          idx_d   = 4'd0;
          done_d  = 1'b1;
        end else begin
          state_d = XFER;
          idx_d   = idx_nxt_s;
          addr_d  = addr_q + STEP;
          rd_d    = ~store_q;
          wr_d    = store_q;
          dout_d  = store_q ? elem(st_q, idx_nxt_s) : 16'h0000;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      store_q <= 1'b0;
      st_q    <= 256'd0;
      ld_q    <= 256'd0;
      addr_q  <= 16'h0000;
      dout_q  <= 16'h0000;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      store_q <= store_d;
      st_q    <= st_d;
      ld_q    <= ld_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Addr    = addr_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign dataOut = dout_q;
  assign ld_data = ld_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
